// File: rtl/grf_hazard_ctrl.sv
// GRF hazard controller: tracks in-flight register writes in E/M/W and the
// multiply/divide busy counter, and from them derives the D-stage stall and
// the forwarding select for each GRF read port.
module grf_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       D_Valid,
  input  logic [4:0] D_RAddr1,
  input  logic [1:0] D_Tuse1,
  input  logic [4:0] D_RAddr2,
  input  logic [1:0] D_Tuse2,
  input  logic       D_RegWrite,
  input  logic [4:0] D_WAddr,
  input  logic [1:0] D_Tnew,
  input  logic [1:0] D_MDStart,
  input  logic       D_MDUse,
  output logic       Stall,
  output logic [1:0] Fwd1Sel,
  output logic [1:0] Fwd2Sel,
  output logic       MDBusy
);

  // One in-flight register write: destination and cycles until forwardable.
  typedef struct packed {
    logic       valid;
    logic [4:0] waddr;
    logic [1:0] tnew;
  } shadow_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  shadow_t    e_reg;
  shadow_t    m_reg;
  shadow_t    w_reg;
  logic [3:0] md_cnt_reg;
  logic       md_start_reg;   // E holds an instruction that starts the MDU
  logic [1:0] md_type_reg;    // 1 mult/multu, 2 div/divu
  logic       issue;
  logic       op_stall;
  logic       md_stall;
  logic [2:0] port1_eval;
  logic [2:0] port2_eval;
  logic       w_tnew_unused;

  // Saturating decrement: an entry that is already forwardable stays at 0.
  function automatic logic [1:0] sat_dec(input logic [1:0] x);
    return (x != 2'd0) ? x - 2'd1 : 2'd0;
  endfunction

  // Returns {stall, fwd_sel} for one read port. The youngest matching entry
  // decides; a W match ends the search with no stall and a GRF read, since
  // the register file writes through to the same-cycle read.
  function automatic logic [2:0] port_eval(
    input logic [4:0] raddr,
    input logic [1:0] tuse,
    input shadow_t    e,
    input shadow_t    m,
    input shadow_t    w
  );
    logic       stall_p;
    logic [1:0] sel;
    stall_p = 1'b0;
    sel     = 2'd0;
    if (raddr != 5'd0) begin
      if (e.valid && e.waddr == raddr) begin
        stall_p = (e.tnew > tuse);
        sel     = (e.tnew == 2'd0) ? 2'd2 : 2'd0;
      end else if (m.valid && m.waddr == raddr) begin
        stall_p = (m.tnew > tuse);
        sel     = (m.tnew == 2'd0) ? 2'd1 : 2'd0;
      end else if (w.valid && w.waddr == raddr) begin
        stall_p = 1'b0;
        sel     = 2'd0;
      end
    end
    return {stall_p, sel};
  endfunction

  // W's remaining latency is kept for observability but never gates anything.
  assign w_tnew_unused = ^w_reg.tnew;

  // Per-port hazard evaluation and the combined stall decision.
  always_comb begin
    port1_eval = port_eval(D_RAddr1, D_Tuse1, e_reg, m_reg, w_reg);
    port2_eval = port_eval(D_RAddr2, D_Tuse2, e_reg, m_reg, w_reg);
    op_stall   = port1_eval[2] | port2_eval[2];
    md_stall   = D_MDUse && ((md_cnt_reg != 4'd0) || md_start_reg);
    Stall      = D_Valid && (op_stall || md_stall);
    Fwd1Sel    = port1_eval[1:0];
    Fwd2Sel    = port2_eval[1:0];
    MDBusy     = (md_cnt_reg != 4'd0);
    issue      = D_Valid && !Stall;
  end

  // Advance the shadow pipeline and the MDU busy counter every cycle; a
  // stalled D simply injects a bubble into E.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      e_reg        <= '0;
      m_reg        <= '0;
      w_reg        <= '0;
      md_cnt_reg   <= 4'd0;
      md_start_reg <= 1'b0;
      md_type_reg  <= 2'd0;
    end else begin
      w_reg        <= {m_reg.valid, m_reg.waddr, sat_dec(m_reg.tnew)};
      m_reg        <= {e_reg.valid, e_reg.waddr, sat_dec(e_reg.tnew)};
      e_reg        <= {issue && D_RegWrite && (D_WAddr != 5'd0), D_WAddr, D_Tnew};
      md_start_reg <= issue && (D_MDStart != 2'd0);
      md_type_reg  <= issue ? D_MDStart : 2'd0;
      if (md_start_reg) begin
        md_cnt_reg <= (md_type_reg == 2'd1) ? MULT_LOAD : DIV_LOAD;
      end else if (md_cnt_reg != 4'd0) begin
        md_cnt_reg <= md_cnt_reg - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Scoreboard bench for grf_hazard_ctrl: the driver applies one D-stage vector
// per cycle and queues its hand-computed response; the monitor pops and
// compares on the falling edge.
module tb_grf_hazard_ctrl;

  logic       Clk;
  logic       Reset;
  logic       D_Valid;
  logic [4:0] D_RAddr1;
  logic [1:0] D_Tuse1;
  logic [4:0] D_RAddr2;
  logic [1:0] D_Tuse2;
  logic       D_RegWrite;
  logic [4:0] D_WAddr;
  logic [1:0] D_Tnew;
  logic [1:0] D_MDStart;
  logic       D_MDUse;
  logic       Stall;
  logic [1:0] Fwd1Sel;
  logic [1:0] Fwd2Sel;
  logic       MDBusy;

  typedef struct {
    string      name;
    logic       stall;
    logic [1:0] f1;
    logic [1:0] f2;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  grf_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .D_Valid(D_Valid),
    .D_RAddr1(D_RAddr1), .D_Tuse1(D_Tuse1),
    .D_RAddr2(D_RAddr2), .D_Tuse2(D_Tuse2),
    .D_RegWrite(D_RegWrite), .D_WAddr(D_WAddr), .D_Tnew(D_Tnew),
    .D_MDStart(D_MDStart), .D_MDUse(D_MDUse),
    .Stall(Stall), .Fwd1Sel(Fwd1Sel), .Fwd2Sel(Fwd2Sel), .MDBusy(MDBusy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Apply one D-stage vector, queue its expected response, advance a cycle.
  task automatic cyc(input string n, input logic v,
                     input logic [4:0] ra1, input logic [1:0] tu1,
                     input logic [4:0] ra2, input logic [1:0] tu2,
                     input logic rw, input logic [4:0] wa, input logic [1:0] tn,
                     input logic [1:0] mds, input logic mdu,
                     input logic es, input logic [1:0] ef1,
                     input logic [1:0] ef2, input logic eb);
    exp_t x;
    D_Valid = v;  D_RAddr1 = ra1; D_Tuse1 = tu1; D_RAddr2 = ra2; D_Tuse2 = tu2;
    D_RegWrite = rw; D_WAddr = wa; D_Tnew = tn; D_MDStart = mds; D_MDUse = mdu;
    x.name = n; x.stall = es; x.f1 = ef1; x.f2 = ef2; x.busy = eb;
    sb.push_back(x);
    @(posedge Clk);
    #1;
  endtask

  // Monitor: the controller presents a response every cycle.
  always @(negedge Clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      total++;
      if ({Stall, Fwd1Sel, Fwd2Sel, MDBusy} !== {x.stall, x.f1, x.f2, x.busy}) begin
        bad++;
        $display("FAIL %s: got stall=%0b f1=%0d f2=%0d busy=%0b, want stall=%0b f1=%0d f2=%0d busy=%0b",
                 x.name, Stall, Fwd1Sel, Fwd2Sel, MDBusy, x.stall, x.f1, x.f2, x.busy);
      end else begin
        $display("ok   %s: stall=%0b f1=%0d f2=%0d busy=%0b",
                 x.name, Stall, Fwd1Sel, Fwd2Sel, MDBusy);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1;
    D_Valid = 0; D_RAddr1 = 0; D_Tuse1 = 0; D_RAddr2 = 0; D_Tuse2 = 0;
    D_RegWrite = 0; D_WAddr = 0; D_Tnew = 0; D_MDStart = 0; D_MDUse = 0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;

    //   name         v ra1 tu1 ra2 tu2 rw wa tn mds mdu | st f1 f2 bz
    cyc("reset_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    // load-use with Tuse=1: one stall cycle, then M entry still has tnew=1
    cyc("lw8",        1, 29, 1, 0, 0, 1, 8, 2, 0, 0,  0, 0, 0, 0);
    cyc("lu_stall",   1, 8, 1, 9, 1, 1, 10, 1, 0, 0,  1, 0, 0, 0);
    cyc("lu_go",      1, 8, 1, 9, 1, 1, 10, 1, 0, 0,  0, 0, 0, 0);
    cyc("lu_w_match", 1, 8, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    // ALU chain
    cyc("alu9_fwdM",  1, 10, 1, 0, 0, 1, 9, 1, 0, 0,  0, 1, 0, 0);
    cyc("alu_rd_t1",  1, 9, 1, 10, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0);
    cyc("alu_rd_t0",  1, 11, 1, 9, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);

    // $0 destination never tracked
    cyc("w0",         1, 11, 1, 0, 0, 1, 0, 1, 0, 0,  0, 1, 0, 0);
    cyc("rd0",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    // youngest match wins
    cyc("w5a",        1, 0, 0, 0, 0, 1, 5, 0, 0, 0,   0, 0, 0, 0);
    cyc("w5b_fwdE",   1, 5, 0, 5, 0, 1, 5, 0, 0, 0,   0, 2, 2, 0);
    cyc("young_E",    1, 5, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2, 0, 0);
    cyc("m_over_w",   1, 5, 0, 5, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0);
    cyc("idle1",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    // mult then mflo: 1 start stall + 5 busy stalls
    cyc("mult",       1, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0);
    cyc("mflo_start", 1, 0, 0, 0, 0, 1, 12, 1, 0, 1,  1, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc("mflo_busy", 1, 0, 0, 0, 0, 1, 12, 1, 0, 1, 1, 0, 0, 1);
    cyc("mflo_go",    1, 0, 0, 0, 0, 1, 12, 1, 0, 1,  0, 0, 0, 0);

    // div then mfhi: 1 start stall + 10 busy cycles (one with D invalid)
    cyc("div",        1, 0, 0, 0, 0, 0, 0, 0, 2, 1,   0, 0, 0, 0);
    cyc("mfhi_start", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0);
    cyc("mfhi_inval", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1);
    for (int i = 0; i < 9; i++)
      cyc("mfhi_busy", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 1);
    cyc("mfhi_go",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);

    // reset while the divider counts down with a live shadow entry
    cyc("div2",       1, 0, 0, 0, 0, 0, 0, 0, 2, 1,   0, 0, 0, 0);
    cyc("w7_a",       1, 0, 0, 0, 0, 1, 7, 0, 0, 0,   0, 0, 0, 0);
    cyc("fwd7_E",     0, 7, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2, 0, 1);
    cyc("fwd7_M",     0, 7, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
    cyc("w7_b",       1, 0, 0, 0, 0, 1, 7, 0, 0, 0,   0, 0, 0, 1);
    Reset = 1'b1;
    cyc("reset_cnt7", 1, 7, 0, 0, 0, 0, 0, 0, 0, 1,   1, 2, 0, 1);
    Reset = 1'b0;
    cyc("post_reset", 1, 7, 0, 7, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);

    // load-use with Tuse=0: two stall cycles (E tnew=2, then M tnew=1)
    cyc("lw3",        1, 0, 0, 0, 0, 1, 3, 2, 0, 0,   0, 0, 0, 0);
    cyc("lu0_stallE", 1, 3, 0, 3, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    cyc("lu0_stallM", 1, 3, 0, 3, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    cyc("lu0_go",     1, 3, 0, 3, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    // invalid D never stalls even with a pending hazard
    cyc("lw4",        1, 0, 0, 0, 0, 1, 4, 2, 0, 0,   0, 0, 0, 0);
    cyc("inval_haz",  0, 4, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    cyc("idle_end",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    @(negedge Clk);
    #1;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d responses left unchecked, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
